dram_port_arbiter: RTL and testbench



---
 rtl/dram_arb_pkg.sv | 17 +
 rtl/dram_arb_pick.sv | 33 +++
 rtl/dram_port_arbiter.sv | 132 +++++++++++++
 tb/tb_dram_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// rtl/dram_arb_pkg.sv - shared state type, port indices and default widths for the DRAM port arbiter
package dram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RDWAIT = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_AUX = 1'b1;

   localparam int DEF_NB            = 32;
   localparam int DEF_MEM_ADDR_SIZE = 12;

endpackage

// File: rtl/dram_arb_pick.sv
// rtl/dram_arb_pick.sv - combinational winner selection; tie policy set by DRAM_ARB_ROUND_ROBIN_EN
module dram_arb_pick
   import dram_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner,
   output logic       valid
);

   assign valid = |req;

`ifdef DRAM_ARB_ROUND_ROBIN_EN
   // On a tie the port that did not win last time goes first.
   always_comb begin
      winner = PORT_CPU;
      if (req == 2'b11)
         winner = ~last;
      else if (req[1])
         winner = PORT_AUX;
   end
`else
   logic unused_last;
   assign unused_last = last;

   always_comb begin
      winner = PORT_CPU;
      if (req == 2'b10)
         winner = PORT_AUX;
   end
`endif

endmodule

// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - two-port REQ/ACK arbiter and sequencer for the single-port DRAM (DRAM_ARB_ROUND_ROBIN_EN selects round-robin ties)
module dram_port_arbiter
   import dram_arb_pkg::*;
#(
   parameter int nb            = DEF_NB,
   parameter int MEM_ADDR_SIZE = DEF_MEM_ADDR_SIZE
) (
   input  logic          CLK,
   input  logic          RST_n,
   input  logic          P0_REQ,
   input  logic          P0_WE,
   input  logic [nb-1:0] P0_ADDR,
   input  logic [nb-1:0] P0_WDATA,
   output logic [nb-1:0] P0_RDATA,
   output logic          P0_ACK,
   input  logic          P1_REQ,
   input  logic          P1_WE,
   input  logic [nb-1:0] P1_ADDR,
   input  logic [nb-1:0] P1_WDATA,
   output logic [nb-1:0] P1_RDATA,
   output logic          P1_ACK,
   output logic          MEM_RD,
   output logic          MEM_WR,
   output logic [nb-1:0] MEM_ADDR,
   output logic [nb-1:0] MEM_DATAIN,
   input  logic [nb-1:0] MEM_DATAOUT
);

   localparam int HI_W = nb - MEM_ADDR_SIZE;

   arb_state_t state;
   logic       win;
   logic       we_q;
   logic       last;
   logic       pick_winner;
   logic       pick_valid;

   logic                     sel_we;
   logic [nb-1:0]            sel_addr;
   logic [nb-1:0]            sel_wdata;
   logic [HI_W-1:0]          sel_hi;
   logic [MEM_ADDR_SIZE-1:0] sel_word;

   dram_arb_pick u_pick (
      .req    ({P1_REQ, P0_REQ}),
      .last   (last),
      .winner (pick_winner),
      .valid  (pick_valid)
   );

   assign sel_we    = pick_winner ? P1_WE    : P0_WE;
   assign sel_addr  = pick_winner ? P1_ADDR  : P0_ADDR;
   assign sel_wdata = pick_winner ? P1_WDATA : P0_WDATA;

   // Only the low word-address bits reach the RAM array; the rest ride along untouched.
   assign {sel_hi, sel_word} = sel_addr;

`ifdef DRAM_ARB_ROUND_ROBIN_EN
   logic last_q;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n)
         last_q <= PORT_AUX;
      else if (state == IDLE && pick_valid)
         last_q <= pick_winner;
   end

   assign last = last_q;
`else
   assign last = PORT_AUX;
`endif

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state      <= IDLE;
         win        <= PORT_CPU;
         we_q       <= 1'b0;
         MEM_RD     <= 1'b0;
         MEM_WR     <= 1'b0;
         MEM_ADDR   <= '0;
         MEM_DATAIN <= '0;
         P0_ACK     <= 1'b0;
         P1_ACK     <= 1'b0;
         P0_RDATA   <= '0;
         P1_RDATA   <= '0;
      end else begin
         MEM_RD <= 1'b0;
         MEM_WR <= 1'b0;
         P0_ACK <= 1'b0;
         P1_ACK <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  win        <= pick_winner;
                  we_q       <= sel_we;
                  MEM_ADDR   <= {sel_hi, sel_word};
                  MEM_DATAIN <= sel_wdata;
                  MEM_RD     <= ~sel_we;
                  MEM_WR     <= sel_we;
                  state      <= ACCESS;
               end
            end
            ACCESS: begin
               // Writes finish as soon as the strobe is gone; reads wait one cycle for the RAM.
               if (we_q) begin
                  P0_ACK <= (win == PORT_CPU);
                  P1_ACK <= (win == PORT_AUX);
                  state  <= RESP;
               end else begin
                  state <= RDWAIT;
               end
            end
            RDWAIT: begin
               if (win == PORT_AUX)
                  P1_RDATA <= MEM_DATAOUT;
               else
                  P0_RDATA <= MEM_DATAOUT;
               P0_ACK <= (win == PORT_CPU);
               P1_ACK <= (win == PORT_AUX);
               state  <= RESP;
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - self-checking bench for dram_port_arbiter with a cycle-schedule reference model
`timescale 1ns/1ps
module tb_dram_port_arbiter;

   typedef struct packed {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req = 2'b00;
   logic [1:0]  we = 2'b00;
   logic [31:0] addr [2];
   logic [31:0] wdata [2];
   logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_datain;
   logic [31:0] mem_dataout = 32'h0;
   logic        p0_ack, p1_ack, mem_rd, mem_wr;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   dram_port_arbiter dut (
      .CLK         (clk),
      .RST_n       (rst_n),
      .P0_REQ      (req[0]),
      .P0_WE       (we[0]),
      .P0_ADDR     (addr[0]),
      .P0_WDATA    (wdata[0]),
      .P0_RDATA    (p0_rdata),
      .P0_ACK      (p0_ack),
      .P1_REQ      (req[1]),
      .P1_WE       (we[1]),
      .P1_ADDR     (addr[1]),
      .P1_WDATA    (wdata[1]),
      .P1_RDATA    (p1_rdata),
      .P1_ACK      (p1_ack),
      .MEM_RD      (mem_rd),
      .MEM_WR      (mem_wr),
      .MEM_ADDR    (mem_addr),
      .MEM_DATAIN  (mem_datain),
      .MEM_DATAOUT (mem_dataout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40)
            $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
      end
   endtask

   // DRAM array: content survives reset of the arbiter.
   logic [31:0] dram [logic [31:0]];
   always @(posedge clk) begin
      if (mem_wr) dram[mem_addr] = mem_datain;
      if (mem_rd) mem_dataout <= dram.exists(mem_addr) ? dram[mem_addr] : 32'h0;
   end

   // Reference model: schedules each granted transaction by edge arithmetic.
   int          edge_no = 0;
   int          m_start = -10;
   int          m_ack = -10;
   int          m_free = 0;
   logic        m_we = 1'b0;
   logic        m_port = 1'b0;
   logic        m_pend = 1'b0;
   logic        m_last = 1'b1;
   logic [31:0] m_addr = 32'h0;
   logic [31:0] m_wdata = 32'h0;
   logic [31:0] m_rval = 32'h0;
   logic [31:0] m_rdata [2];
   logic [31:0] golden [logic [31:0]];

   always @(posedge clk) begin
      edge_no++;
      if (!rst_n) begin
         m_start = -10; m_ack = -10; m_free = edge_no;
         m_we = 1'b0; m_port = 1'b0; m_pend = 1'b0; m_last = 1'b1;
         m_addr = 32'h0; m_wdata = 32'h0; m_rval = 32'h0;
         m_rdata[0] = 32'h0; m_rdata[1] = 32'h0;
      end else begin
         if (m_pend && edge_no == m_start + 1) begin
            golden[m_addr] = m_wdata;
            m_pend = 1'b0;
         end
         if (edge_no == m_ack && !m_we) m_rdata[m_port] = m_rval;
         if (edge_no >= m_free && req != 2'b00) begin
            if (req == 2'b11) begin
`ifdef DRAM_ARB_ROUND_ROBIN_EN
               m_port = ~m_last;
`else
               m_port = 1'b0;
`endif
            end else begin
               m_port = req[1];
            end
            m_last  = m_port;
            m_we    = we[m_port];
            m_addr  = addr[m_port];
            m_wdata = wdata[m_port];
            m_rval  = golden.exists(m_addr) ? golden[m_addr] : 32'h0;
            m_pend  = m_we;
            m_start = edge_no;
            m_ack   = edge_no + (m_we ? 1 : 2);
            m_free  = edge_no + (m_we ? 3 : 4);
         end
      end
   end

   logic        chk_en = 1'b0;
   logic        e_rd, e_wr, e_a0, e_a1;
   logic [31:0] e_addr, e_din, e_r0, e_r1;

   always @(negedge clk) begin
      if (chk_en) begin
         if (!rst_n) begin
            e_rd = 1'b0; e_wr = 1'b0; e_a0 = 1'b0; e_a1 = 1'b0;
            e_addr = 32'h0; e_din = 32'h0; e_r0 = 32'h0; e_r1 = 32'h0;
         end else begin
            e_rd   = (edge_no == m_start) && !m_we;
            e_wr   = (edge_no == m_start) && m_we;
            e_a0   = (edge_no == m_ack) && (m_port == 1'b0);
            e_a1   = (edge_no == m_ack) && (m_port == 1'b1);
            e_addr = m_addr;
            e_din  = m_wdata;
            e_r0   = m_rdata[0];
            e_r1   = m_rdata[1];
         end
         check("mem_rd", {31'h0, mem_rd}, {31'h0, e_rd});
         check("mem_wr", {31'h0, mem_wr}, {31'h0, e_wr});
         check("mem_addr", mem_addr, e_addr);
         check("mem_datain", mem_datain, e_din);
         check("p0_ack", {31'h0, p0_ack}, {31'h0, e_a0});
         check("p1_ack", {31'h0, p1_ack}, {31'h0, e_a1});
         check("p0_rdata", p0_rdata, e_r0);
         check("p1_rdata", p1_rdata, e_r1);
         check("strobe_excl", {31'h0, mem_rd & mem_wr}, 32'h0);
      end
   end

   // Requesters: hold REQ until ACK, then move straight on to the next queued transaction.
   txn_t        q0 [$];
   txn_t        q1 [$];
   int          done [2];
   int          lat [2];
   int          raise_e [2];
   logic [31:0] got_rd [2];
   int          ack_log [$];
   txn_t        t;
   logic        got, ak;

   always begin
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
         ak = (p == 0) ? p0_ack : p1_ack;
         if (req[p] && ak) begin
            done[p]++;
            lat[p] = edge_no - raise_e[p];
            got_rd[p] = (p == 0) ? p0_rdata : p1_rdata;
            ack_log.push_back(p);
            req[p] = 1'b0;
         end
         if (!req[p]) begin
            got = 1'b0;
            if (p == 0 && q0.size() != 0) begin t = q0.pop_front(); got = 1'b1; end
            if (p == 1 && q1.size() != 0) begin t = q1.pop_front(); got = 1'b1; end
            if (got) begin
               req[p] = 1'b1; we[p] = t.w; addr[p] = t.a; wdata[p] = t.d;
               raise_e[p] = edge_no;
            end
         end
      end
   end

   task automatic push(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
      txn_t x;
      x.w = w; x.a = a; x.d = d;
      if (p == 0) q0.push_back(x); else q1.push_back(x);
   endtask

   task automatic wait_done(input int p, input int target, input string name);
      int n;
      n = 0;
      while (done[p] < target && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(name, done[p], target);
   endtask

   task automatic wait_strobe(input logic want_wr, input string name);
      int n;
      n = 0;
      while (((want_wr ? mem_wr : mem_rd) !== 1'b1) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'h0, (want_wr ? mem_wr : mem_rd)}, 32'h1);
   endtask

   int exp_order [4];
   int n_rand [2];

   initial begin
      addr[0] = 32'h0; addr[1] = 32'h0; wdata[0] = 32'h0; wdata[1] = 32'h0;
      done[0] = 0; done[1] = 0; lat[0] = 0; lat[1] = 0;
      raise_e[0] = 0; raise_e[1] = 0; got_rd[0] = 32'h0; got_rd[1] = 32'h0;
      n_rand[0] = 0; n_rand[1] = 0;

      // Reset held with both ports requesting.
      push(0, 1'b0, 32'h020, 32'h0);
      push(1, 1'b0, 32'h024, 32'h0);
      @(posedge clk);
      chk_en = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_strobes", {28'h0, mem_rd, mem_wr, p0_ack, p1_ack}, 32'h0);
      check("rst_addr", mem_addr, 32'h0);
      @(posedge clk); #2 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("first_grant_rd", {31'h0, mem_rd}, 32'h1);
      check("first_grant_addr", mem_addr, 32'h020);
      wait_done(0, 1, "t1_p0_done");
      wait_done(1, 1, "t1_p1_done");
      check("t1_order0", ack_log[0], 0);
      check("t1_order1", ack_log[1], 1);

      // Single write from port 0.
      push(0, 1'b1, 32'h010, 32'hDEADBEEF);
      @(negedge clk);
      wait_strobe(1'b1, "wr_strobe");
      check("wr_addr", mem_addr, 32'h010);
      check("wr_data", mem_datain, 32'hDEADBEEF);
      @(negedge clk);
      check("wr_ack", {30'h0, p1_ack, p0_ack}, 32'h1);
      wait_done(0, 2, "wr_done");
      check("wr_latency", lat[0], 2);

      // Single read from port 1.
      push(1, 1'b0, 32'h010, 32'h0);
      @(negedge clk);
      wait_strobe(1'b0, "rd_strobe");
      check("rd_addr", mem_addr, 32'h010);
      @(negedge clk);
      check("rd_no_early_ack", {30'h0, p1_ack, p0_ack}, 32'h0);
      @(negedge clk);
      check("rd_ack", {30'h0, p1_ack, p0_ack}, 32'h2);
      check("rd_data", p1_rdata, 32'hDEADBEEF);
      check("rd_p0_unchanged", p0_rdata, 32'h0);
      wait_done(1, 2, "rd_done");
      check("rd_latency", lat[1], 3);

      // Contention: four writes queued on each port at once.
      ack_log.delete();
      for (int i = 0; i < 4; i++) begin
         push(0, 1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
         push(1, 1'b1, 32'h200 + 32'(4 * i), 32'hB000_0000 + 32'(i));
      end
`ifdef DRAM_ARB_ROUND_ROBIN_EN
      exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
`else
      exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0; exp_order[3] = 0;
`endif
      wait_done(0, 6, "cont_p0_done");
      wait_done(1, 6, "cont_p1_done");
      for (int i = 0; i < 4; i++)
         check($sformatf("cont_order%0d", i), ack_log[i], exp_order[i]);

      // Reset during the read-wait cycle; the requester keeps asking and is served afresh.
      push(1, 1'b0, 32'h010, 32'h0);
      @(negedge clk);
      wait_strobe(1'b0, "mid_rd_strobe");
      @(posedge clk); #2 rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_ack", {30'h0, p1_ack, p0_ack}, 32'h0);
      check("mid_rst_rdata", p1_rdata, 32'h0);
      check("mid_rst_strobe", {30'h0, mem_rd, mem_wr}, 32'h0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      wait_done(1, 7, "mid_rst_done");
      check("mid_rst_reread", got_rd[1], 32'hDEADBEEF);

      // Random traffic on both ports.
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (q0.size() == 0 && $urandom_range(0, 3) == 0) begin
            push(0, 1'($urandom_range(0, 1)), {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
            n_rand[0]++;
         end
         if (q1.size() == 0 && $urandom_range(0, 3) == 0) begin
            push(1, 1'($urandom_range(0, 1)), {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
            n_rand[1]++;
         end
      end
      wait_done(0, 6 + n_rand[0], "rand_p0_done");
      wait_done(1, 7 + n_rand[1], "rand_p1_done");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
